// File: rtl/exec_pkg.sv
// exec_pkg: shared constants, types and the branch condition evaluator for execute_pipe
package exec_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_DEF = 16;
  localparam logic [4:0] UOP_ADD = 5'd0;
  localparam logic [4:0] UOP_SUB = 5'd1;
  localparam logic [4:0] UOP_AND = 5'd2;
  localparam logic [4:0] UOP_ORR = 5'd3;
  localparam logic [4:0] UOP_EOR = 5'd4;
  localparam logic [4:0] UOP_MOV = 5'd5;
  localparam logic [4:0] UOP_LSL = 5'd6;
  localparam logic [4:0] UOP_LSR = 5'd7;
  localparam logic [4:0] UOP_ASR = 5'd8;
  localparam logic [4:0] UOP_MVN = 5'd9;
  localparam logic [4:0] UOP_LOAD = 5'd10;
  localparam logic [4:0] UOP_STORE = 5'd11;
  localparam logic [4:0] UOP_BRANCH = 5'd12;
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef enum logic [1:0] {RUN, MEM_WAIT, SHADOW} state_t;
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    case (cond)
      COND_EQ: return f[FLAG_Z];
      COND_NE: return !f[FLAG_Z];
      COND_CS: return f[FLAG_C];
      COND_CC: return !f[FLAG_C];
      COND_MI: return f[FLAG_N];
      COND_PL: return !f[FLAG_N];
      COND_VS: return f[FLAG_V];
      COND_VC: return !f[FLAG_V];
      COND_HI: return f[FLAG_C] && !f[FLAG_Z];
      COND_LS: return !f[FLAG_C] || f[FLAG_Z];
      COND_GE: return f[FLAG_N] == f[FLAG_V];
      COND_LT: return f[FLAG_N] != f[FLAG_V];
      COND_GT: return !f[FLAG_Z] && f[FLAG_N] == f[FLAG_V];
      COND_LE: return f[FLAG_Z] || f[FLAG_N] != f[FLAG_V];
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/exec_alu.sv
// exec_alu: combinational ALU producing a result and NZCV; carry/overflow only from ADD and SUB
module exec_alu import exec_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y,
  output logic [3:0]      nzcv
);
  localparam int SH = $clog2(XLEN);
  logic [XLEN:0] sum, dif;
  logic [SH-1:0] amt;
  logic v_add, v_sub;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} + {1'b0, ~b} + (XLEN+1)'(1);
  assign amt = b[SH-1:0];
  assign v_add = a[XLEN-1] == b[XLEN-1] && sum[XLEN-1] != a[XLEN-1];
  assign v_sub = a[XLEN-1] != b[XLEN-1] && dif[XLEN-1] != a[XLEN-1];
  always_comb begin
    case (op)
      UOP_SUB: y = dif[XLEN-1:0];
      UOP_AND: y = a & b;
      UOP_ORR: y = a | b;
      UOP_EOR: y = a ^ b;
      UOP_MOV: y = b;
      UOP_LSL: y = a << amt;
      UOP_LSR: y = a >> amt;
      UOP_ASR: y = $signed(a) >>> amt;
      UOP_MVN: y = ~b;
      default: y = sum[XLEN-1:0];
    endcase
  end
  assign nzcv = {y[XLEN-1], ~|y,
                 op == UOP_ADD ? sum[XLEN] : op == UOP_SUB && dif[XLEN],
                 op == UOP_ADD ? v_add : op == UOP_SUB && v_sub};
endmodule

// File: rtl/exec_regfile.sv
// exec_regfile: register array and NZCV flags with write-through bypass on both read ports
module exec_regfile #(
  parameter int XLEN = 32,
  parameter int NREGS = 16,
  localparam int RW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [RW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            flags_we,
  input  logic [3:0]      flags_in,
  input  logic [RW-1:0]   ra0,
  input  logic [RW-1:0]   ra1,
  output logic [XLEN-1:0] rd0,
  output logic [XLEN-1:0] rd1,
  output logic [3:0]      flags
);
  logic [XLEN-1:0] regs [NREGS];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      flags <= '0;
    end else begin
      if (we) regs[waddr] <= wdata;
      if (flags_we) flags <= flags_in;
    end
  assign rd0 = we && waddr == ra0 ? wdata : regs[ra0];
  assign rd1 = we && waddr == ra1 ? wdata : regs[ra1];
endmodule

// File: rtl/execute_pipe.sv
// execute_pipe: single EX stage with bypassed register file, req/ack memory port and branch shadow squash
module execute_pipe import exec_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int SHADOW_DEPTH = 2,
  localparam int RW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            num_to_rhs,
  input  logic [XLEN-1:0] num,
  input  logic [RW-1:0]   sel_p0,
  input  logic [RW-1:0]   sel_p1,
  input  logic [RW-1:0]   sel_in,
  input  logic [4:0]      uop,
  input  logic [3:0]      branch_cond,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] delta_instruction,
  output logic            retire_valid
);
  localparam int SW = SHADOW_DEPTH > 0 ? $clog2(SHADOW_DEPTH + 1) : 1;
  state_t state;
  logic [SW-1:0] shadow_cnt;
  logic ex_valid, ex_rhs_num;
  logic [XLEN-1:0] ex_p0, ex_p1, ex_num, rd0, rd1, alu_y, rf_wdata;
  logic [4:0] ex_uop;
  logic [3:0] ex_cond, flags, alu_nzcv;
  logic [RW-1:0] ex_dst;
  logic accept, live, is_alu, is_mem, taken, mem_done, rf_we;
  assign accept = in_valid && in_ready;
  // anything reaching EX while the shadow is open is wrong-path work
  assign live = ex_valid && state != SHADOW;
  assign is_alu = ex_uop < UOP_LOAD;
  assign is_mem = ex_uop == UOP_LOAD || ex_uop == UOP_STORE;
  assign taken = live && ex_uop == UOP_BRANCH && cond_pass(ex_cond, flags);
  assign mem_done = mem_req && mem_ack;
  assign in_ready = state != MEM_WAIT && !(ex_valid && is_mem);
  assign redirect_valid = taken;
  assign delta_instruction = taken ? ex_num : '0;
  assign retire_valid = (live && !is_mem) || mem_done;
  // ex_dst is frozen during MEM_WAIT, so it still names the load destination at ack
  assign rf_we = (live && is_alu) || (mem_done && !mem_we);
  assign rf_wdata = mem_done ? mem_rdata : alu_y;
  exec_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk(clk), .reset(reset), .we(rf_we), .waddr(ex_dst), .wdata(rf_wdata),
    .flags_we(live && is_alu), .flags_in(alu_nzcv),
    .ra0(sel_p0), .ra1(sel_p1), .rd0(rd0), .rd1(rd1), .flags(flags)
  );
  exec_alu #(.XLEN(XLEN)) u_alu (
    .op(is_alu ? ex_uop : UOP_ADD), .a(ex_p1), .b(ex_rhs_num ? ex_num : ex_p0),
    .y(alu_y), .nzcv(alu_nzcv)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ex_valid <= 1'b0;
      ex_rhs_num <= 1'b0;
      ex_p0 <= '0;
      ex_p1 <= '0;
      ex_num <= '0;
      ex_uop <= '0;
      ex_cond <= '0;
      ex_dst <= '0;
    end else begin
      ex_valid <= accept;
      if (accept) begin
        ex_rhs_num <= num_to_rhs;
        ex_p0 <= rd0;
        ex_p1 <= rd1;
        ex_num <= num;
        ex_uop <= uop;
        ex_cond <= branch_cond;
        ex_dst <= sel_in;
      end
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RUN;
      shadow_cnt <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else if (mem_done) begin
      state <= RUN;
      mem_req <= 1'b0;
    end else if (live && is_mem) begin
      state <= MEM_WAIT;
      mem_req <= 1'b1;
      mem_we <= ex_uop == UOP_STORE;
      mem_addr <= alu_y;
      mem_wdata <= ex_p0;
    end else if (taken && SHADOW_DEPTH > 0) begin
      state <= SHADOW;
      shadow_cnt <= SW'(SHADOW_DEPTH);
    end else if (ex_valid && state == SHADOW) begin
      shadow_cnt <= shadow_cnt - 1'b1;
      if (shadow_cnt == SW'(1)) state <= RUN;
    end
endmodule

// File: tb/tb_execute_pipe.sv
// tb_execute_pipe: directed scenario tasks for execute_pipe with hand-computed expectations
module tb_execute_pipe;
  import exec_pkg::*;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, num_to_rhs = 1'b0, mem_ack = 1'b0;
  logic [31:0] num = '0, mem_rdata = '0;
  logic [3:0] sel_p0 = '0, sel_p1 = '0, sel_in = '0, branch_cond = '0;
  logic [4:0] uop = '0;
  logic in_ready, mem_req, mem_we, redirect_valid, retire_valid;
  logic [31:0] mem_addr, mem_wdata, delta_instruction;
  int tests = 0, fails = 0;
  execute_pipe #(.XLEN(32), .NREGS(16), .SHADOW_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .num_to_rhs(num_to_rhs), .num(num), .sel_p0(sel_p0), .sel_p1(sel_p1), .sel_in(sel_in),
    .uop(uop), .branch_cond(branch_cond), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .delta_instruction(delta_instruction),
    .retire_valid(retire_valid)
  );
  always #5 clk = ~clk;
  task automatic issue(input logic [4:0] u, input int d, input int a, input int b,
                       input logic rn, input logic [31:0] n, input logic [3:0] c);
    @(negedge clk);
    in_valid = 1'b1; uop = u; sel_in = 4'(d); sel_p1 = 4'(a); sel_p0 = 4'(b);
    num_to_rhs = rn; num = n; branch_cond = c;
    #1;
  endtask
  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests++; if ({mem_req, mem_we, redirect_valid, retire_valid} !== 4'b0) begin fails++; $display("FAIL reset_ctrl got=%b exp=0000", {mem_req, mem_we, redirect_valid, retire_valid}); end
    tests++; if ({delta_instruction, mem_addr, mem_wdata} !== 96'h0) begin fails++; $display("FAIL reset_data got=%h/%h/%h exp=0", delta_instruction, mem_addr, mem_wdata); end
    tests++; if (dut.u_rf.regs[1] !== 32'h0) begin fails++; $display("FAIL reset_r1 got=%h exp=0", dut.u_rf.regs[1]); end
  endtask
  task automatic test_alu_bypass();
    issue(UOP_ADD, 1, 1, 0, 1'b1, 32'd5, 4'd0);
    tests++; if (retire_valid !== 1'b0) begin fails++; $display("FAIL alu_retire0 got=%b exp=0", retire_valid); end
    issue(UOP_ADD, 2, 1, 1, 1'b0, 32'd0, 4'd0);
    tests++; if (retire_valid !== 1'b1) begin fails++; $display("FAIL alu_retire1 got=%b exp=1", retire_valid); end
    idle();
    tests++; if (retire_valid !== 1'b1) begin fails++; $display("FAIL alu_retire2 got=%b exp=1", retire_valid); end
    tests++; if (dut.u_rf.regs[1] !== 32'd5) begin fails++; $display("FAIL alu_r1 got=%h exp=5", dut.u_rf.regs[1]); end
    idle();
    tests++; if (retire_valid !== 1'b0) begin fails++; $display("FAIL alu_retire3 got=%b exp=0", retire_valid); end
    tests++; if (dut.u_rf.regs[2] !== 32'd10) begin fails++; $display("FAIL alu_r2_bypass got=%h exp=a", dut.u_rf.regs[2]); end
  endtask
  task automatic test_store();
    int n = 0;
    issue(UOP_ADD, 3, 0, 0, 1'b1, 32'h1234, 4'd0);
    idle();
    issue(UOP_STORE, 0, 0, 3, 1'b1, 32'h40, 4'd0);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL st_accept_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      mem_ack = n == 2;
      #1;
      if (i == 0 || mem_req) begin
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL st_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      end
      if (mem_req) begin
        n++;
        tests++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h40, 32'h1234}) begin fails++; $display("FAIL st_bus we=%b addr=%h wdata=%h exp=1/40/1234", mem_we, mem_addr, mem_wdata); end
        tests++; if (retire_valid !== mem_ack) begin fails++; $display("FAIL st_retire cyc=%0d got=%b exp=%b", i, retire_valid, mem_ack); end
      end
    end
    mem_ack = 1'b0;
    tests++; if (n !== 3) begin fails++; $display("FAIL st_req_cycles got=%0d exp=3", n); end
    tests++; if ({in_ready, mem_req} !== 2'b10) begin fails++; $display("FAIL st_after got=%b exp=10", {in_ready, mem_req}); end
  endtask
  task automatic test_load();
    issue(UOP_LOAD, 4, 0, 0, 1'b1, 32'h40, 4'd0);
    idle();
    tests++; if ({in_ready, mem_req} !== 2'b00) begin fails++; $display("FAIL ld_ex got=%b exp=00", {in_ready, mem_req}); end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE;
    #1;
    tests++; if ({mem_req, mem_we, retire_valid} !== 3'b101) begin fails++; $display("FAIL ld_req got=%b exp=101", {mem_req, mem_we, retire_valid}); end
    tests++; if (mem_addr !== 32'h40) begin fails++; $display("FAIL ld_addr got=%h exp=40", mem_addr); end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    tests++; if ({in_ready, mem_req} !== 2'b10) begin fails++; $display("FAIL ld_done got=%b exp=10", {in_ready, mem_req}); end
    tests++; if (dut.u_rf.regs[4] !== 32'hCAFE) begin fails++; $display("FAIL ld_r4 got=%h exp=cafe", dut.u_rf.regs[4]); end
  endtask
  task automatic test_branch_taken();
    issue(UOP_SUB, 5, 5, 5, 1'b0, 32'd0, 4'd0);
    issue(UOP_BRANCH, 0, 0, 0, 1'b1, 32'hFFFFFFF8, COND_EQ);
    tests++; if (retire_valid !== 1'b1) begin fails++; $display("FAIL bt_sub_retire got=%b exp=1", retire_valid); end
    idle();
    tests++; if (redirect_valid !== 1'b1) begin fails++; $display("FAIL bt_redirect got=%b exp=1", redirect_valid); end
    tests++; if (delta_instruction !== 32'hFFFFFFF8) begin fails++; $display("FAIL bt_delta got=%h exp=fffffff8", delta_instruction); end
    issue(UOP_ADD, 6, 0, 0, 1'b1, 32'd1, 4'd0);
    tests++; if ({redirect_valid, delta_instruction} !== 33'h0) begin fails++; $display("FAIL bt_pulse_end got=%b/%h exp=0/0", redirect_valid, delta_instruction); end
    issue(UOP_ADD, 7, 0, 0, 1'b1, 32'd2, 4'd0);
    tests++; if (retire_valid !== 1'b0) begin fails++; $display("FAIL bt_squash1 got=%b exp=0", retire_valid); end
    issue(UOP_ADD, 8, 0, 0, 1'b1, 32'd3, 4'd0);
    tests++; if (retire_valid !== 1'b0) begin fails++; $display("FAIL bt_squash2 got=%b exp=0", retire_valid); end
    idle();
    tests++; if (retire_valid !== 1'b1) begin fails++; $display("FAIL bt_third_retire got=%b exp=1", retire_valid); end
    tests++; if ({dut.u_rf.regs[6], dut.u_rf.regs[7]} !== 64'h0) begin fails++; $display("FAIL bt_squash_regs got=%h/%h exp=0/0", dut.u_rf.regs[6], dut.u_rf.regs[7]); end
    idle();
    tests++; if (dut.u_rf.regs[8] !== 32'd3) begin fails++; $display("FAIL bt_r8 got=%h exp=3", dut.u_rf.regs[8]); end
  endtask
  task automatic test_branch_not_taken();
    issue(UOP_SUB, 5, 5, 5, 1'b0, 32'd0, 4'd0);
    issue(UOP_BRANCH, 0, 0, 0, 1'b1, 32'h100, COND_NE);
    issue(UOP_ADD, 9, 0, 0, 1'b1, 32'd9, 4'd0);
    tests++; if ({redirect_valid, delta_instruction} !== 33'h0) begin fails++; $display("FAIL bn_redirect got=%b/%h exp=0/0", redirect_valid, delta_instruction); end
    tests++; if (retire_valid !== 1'b1) begin fails++; $display("FAIL bn_br_retire got=%b exp=1", retire_valid); end
    idle();
    tests++; if (retire_valid !== 1'b1) begin fails++; $display("FAIL bn_add_retire got=%b exp=1", retire_valid); end
    idle();
    tests++; if (dut.u_rf.regs[9] !== 32'd9) begin fails++; $display("FAIL bn_r9 got=%h exp=9", dut.u_rf.regs[9]); end
  endtask
  task automatic test_r0_write();
    issue(UOP_ADD, 0, 0, 0, 1'b1, 32'd7, 4'd0);
    idle();
    idle();
    tests++; if (dut.u_rf.regs[0] !== 32'd7) begin fails++; $display("FAIL r0_write got=%h exp=7", dut.u_rf.regs[0]); end
  endtask
  task automatic test_reset_mid_load();
    issue(UOP_LOAD, 10, 5, 0, 1'b1, 32'h80, 4'd0);
    idle();
    idle();
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rl_req got=%b exp=1", mem_req); end
    #2 reset = 1'b1;
    #1;
    tests++; if ({mem_req, redirect_valid, retire_valid} !== 3'b000) begin fails++; $display("FAIL rl_async got=%b exp=000", {mem_req, redirect_valid, retire_valid}); end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD;
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++; if ({in_ready, mem_req, retire_valid} !== 3'b100) begin fails++; $display("FAIL rl_release got=%b exp=100", {in_ready, mem_req, retire_valid}); end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    tests++; if (dut.u_rf.regs[10] !== 32'h0) begin fails++; $display("FAIL rl_r10 got=%h exp=0", dut.u_rf.regs[10]); end
    tests++; if (dut.u_rf.regs[0] !== 32'h0) begin fails++; $display("FAIL rl_r0 got=%h exp=0", dut.u_rf.regs[0]); end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_alu_bypass();
    test_store();
    test_load();
    test_branch_taken();
    test_branch_not_taken();
    test_r0_write();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
